// File: rtl/d_latch_pkg.sv
// Shared defaults for the d_latch block: data width and reset value.
package d_latch_pkg;

    localparam int   DEF_WIDTH   = 1;
    localparam logic DEF_RST_BIT = 1'b0;

endpackage : d_latch_pkg

// File: rtl/d_latch_cell.sv
// One-bit level-sensitive latch with asynchronous active-high reset.
module d_latch_cell
    import d_latch_pkg::*;
#(
    parameter logic RST_BIT = DEF_RST_BIT
) (
    input  logic d,
    input  logic en,
    input  logic rst,
    output logic q
);

    // Reset dominates; otherwise transparent while en is high, holding while low.
    always_latch begin
        if (rst) begin
            q <= RST_BIT;
        end else if (en) begin
            q <= d;
        end
    end

endmodule : d_latch_cell

// File: rtl/d_latch.sv
// WIDTH-bit transparent latch built from independent per-bit cells.
// Optional simulation checks are compiled in when D_LATCH_ASSERT_EN is defined.
module d_latch
    import d_latch_pkg::*;
#(
    parameter int                 WIDTH   = DEF_WIDTH,
    parameter logic [WIDTH-1:0]   RST_VAL = {WIDTH{DEF_RST_BIT}}
) (
    input  logic [WIDTH-1:0] din,
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] qout
);

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_bit
            d_latch_cell #(
                .RST_BIT (RST_VAL[i])
            ) u_cell (
                .d   (din[i]),
                .en  (clk),
                .rst (rst),
                .q   (qout[i])
            );
        end
    endgenerate

`ifdef D_LATCH_ASSERT_EN
    // Level checks re-evaluated on every input or output change.
    always @(din or clk or rst or qout) begin
        if ($isunknown(clk) || $isunknown(rst)) begin
            $error("d_latch: clk or rst is X/Z");
        end else if (rst) begin
            if (qout !== RST_VAL) begin
                $error("d_latch: qout %h not reset value %h", qout, RST_VAL);
            end
        end else if (clk) begin
            if ($isunknown(din)) begin
                $error("d_latch: din X/Z while transparent");
            end else if (qout !== din) begin
                $error("d_latch: qout %h does not follow din %h", qout, din);
            end
        end
    end

    // The output may only move while reset or transparent.
    always @(qout) begin
        if (rst === 1'b0 && clk === 1'b0) begin
            $error("d_latch: qout changed while holding");
        end
    end
`endif

endmodule : d_latch

// File: tb/tb_d_latch.sv
// Directed testbench for d_latch: WIDTH=1 default instance plus WIDTH=8, RST_VAL=8'hA5.
module tb_d_latch;

    logic       clk;
    logic       rst;
    logic [0:0] din;
    logic [0:0] qout;
    logic       rst8;
    logic [7:0] din8;
    logic [7:0] qout8;

    int checks;
    int failures;

    d_latch u_dut (
        .din  (din),
        .clk  (clk),
        .rst  (rst),
        .qout (qout)
    );

    d_latch #(
        .WIDTH   (8),
        .RST_VAL (8'hA5)
    ) u_dut8 (
        .din  (din8),
        .clk  (clk),
        .rst  (rst8),
        .qout (qout8)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic at(input longint unsigned t);
        #(t - $time);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst  = 1'b1;
        din  = 1'b0;
        rst8 = 1'b1;
        din8 = 8'h3C;

        at(1);   check_val("rst_w1",      {7'd0, qout}, 8'h00);
                 check_val("rst_w8_clk0", qout8, 8'hA5);
        at(10);  din = 1'b1;
        at(11);  check_val("rst_dom_din", {7'd0, qout}, 8'h00);
        at(20);  din = 1'b0;
        at(30);  rst = 1'b0;
        at(40);  check_val("rel_clk_low", {7'd0, qout}, 8'h00);
        at(55);  check_val("transp_0",    {7'd0, qout}, 8'h00);
                 check_val("rst_w8_clk1", qout8, 8'hA5);
        at(60);  din = 1'b1;
        at(61);  check_val("transp_rise", {7'd0, qout}, 8'h01);
        at(70);  rst = 1'b1;
        at(71);  check_val("async_rst",   {7'd0, qout}, 8'h00);
        at(80);  din = 1'b0;
        at(81);  check_val("rst_hold_0",  {7'd0, qout}, 8'h00);
        at(115); rst = 1'b0;
        at(116); check_val("rel_low_a",   {7'd0, qout}, 8'h00);
        at(125); din = 1'b1;
        at(126); check_val("rel_low_b",   {7'd0, qout}, 8'h00);
        at(151); check_val("clk_rise",    {7'd0, qout}, 8'h01);
        at(160); din = 1'b0;
        at(161); check_val("pulse_lo",    {7'd0, qout}, 8'h00);
        at(170); din = 1'b1;
        at(171); check_val("pulse_hi",    {7'd0, qout}, 8'h01);
        at(201); check_val("fall_capt",   {7'd0, qout}, 8'h01);
        at(210); din = 1'b0;
        at(211); check_val("hold",        {7'd0, qout}, 8'h01);
        at(220); rst = 1'b1;
        at(221); check_val("rst_in_hold", {7'd0, qout}, 8'h00);
        at(240); rst = 1'b0;
        at(241); check_val("rst_rel_hold", {7'd0, qout}, 8'h00);
        at(251); check_val("rise_din0",   {7'd0, qout}, 8'h00);
        at(275); din = 1'b1;
        at(276); check_val("follow_275",  {7'd0, qout}, 8'h01);

        // Wide instance: release reset while transparent, then hold across a fall.
        at(281); check_val("w8_rst",      qout8, 8'hA5);
        at(285); rst8 = 1'b0;
        at(286); check_val("w8_rel_clk1", qout8, 8'h3C);
        at(290); din8 = 8'hC3;
        at(291); check_val("w8_follow",   qout8, 8'hC3);
        at(310); din8 = 8'h5A;
        at(311); check_val("w8_hold",     qout8, 8'hC3);
                 check_val("w1_hold_300", {7'd0, qout}, 8'h01);
        at(320); rst8 = 1'b1;
        at(321); check_val("w8_rst_hold", qout8, 8'hA5);
        at(330); rst8 = 1'b0;
        at(351); check_val("w8_rise",     qout8, 8'h5A);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_d_latch
